// File: rtl/bus_tmo_if.sv
// CPU bus request/acknowledge bundle watched by the bus timeout monitor.
// The master side is the CPU plus the responding memory or device; the slave side is bus_tmo.
interface bus_tmo_if #(
  parameter int ADDR_W = 36,
  parameter int ERR_W  = 8
);

  // Request side
  logic              busREQ;
  logic              busIO;
  logic [0:ADDR_W-1] busADDR;
  logic              busACK;
  logic              errCLR;

  // Status side
  logic              busWAIT;
  logic              nxmINTR;
  logic              nxdINTR;
  logic              ioBUSY;
  logic [0:ADDR_W-1] errADDR;
  logic [ERR_W-1:0]  errCOUNT;

  modport master (
    output busREQ, busIO, busADDR, busACK, errCLR,
    input  busWAIT, nxmINTR, nxdINTR, ioBUSY, errADDR, errCOUNT
  );

  modport slave (
    input  busREQ, busIO, busADDR, busACK, errCLR,
    output busWAIT, nxmINTR, nxdINTR, ioBUSY, errADDR, errCOUNT
  );

endinterface

// File: rtl/bus_tmo.sv
// Bus timeout monitor: stalls the CPU while a request is outstanding and fails it
// after TMO_CYCLES unacknowledged cycles, recording sticky NXM/NXD flags and the address.
module bus_tmo #(
  parameter int TMO_CYCLES = 16,
  parameter int CNT_W      = 5,
  parameter int ADDR_W     = 36,
  parameter int ERR_W      = 8
) (
  input  logic     clk,
  input  logic     rst,
  bus_tmo_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAIL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              io_q,       io_d;
  logic [0:ADDR_W-1] addr_q,     addr_d;
  logic              nxm_q,      nxm_d;
  logic              nxd_q,      nxd_d;
  logic [0:ADDR_W-1] err_addr_q, err_addr_d;
  logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
  logic              fail_entry;

  // NOTE: every variable gets its hold value first so no path through the case leaves
  // one unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    io_d       = io_q;
    addr_d     = addr_q;
    nxm_d      = nxm_q;
    nxd_d      = nxd_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    fail_entry = 1'b0;

    if (bus.errCLR) begin
      nxm_d     = 1'b0;
      nxd_d     = 1'b0;
      err_cnt_d = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.busREQ) begin
          state_d = ST_WAIT;
          io_d    = bus.busIO;
          addr_d  = bus.busADDR;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        // Acknowledge outranks both an abort and the timeout in the same cycle.
        if (bus.busACK) begin
          state_d = ST_DRAIN;
        end else if (!bus.busREQ) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = ST_FAIL;
          fail_entry = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FAIL: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.busREQ) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Applied after the clear so a coincident errCLR still leaves this failure recorded.
    if (fail_entry) begin
      if (io_q) begin
        nxd_d = 1'b1;
      end else begin
        nxm_d = 1'b1;
      end
      err_addr_d = addr_q;
      if (bus.errCLR) begin
        err_cnt_d = ERR_W'(1);
      end else if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      io_q       <= 1'b0;
      addr_q     <= '0;
      nxm_q      <= 1'b0;
      nxd_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      io_q       <= io_d;
      addr_q     <= addr_d;
      nxm_q      <= nxm_d;
      nxd_q      <= nxd_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Gated by rst because the state register only becomes IDLE at the first reset edge.
  assign bus.busWAIT  = !rst && (((state_q == ST_IDLE) && bus.busREQ) ||
                                 ((state_q == ST_WAIT) && !bus.busACK));
  assign bus.ioBUSY   = !rst && (state_q != ST_IDLE);
  assign bus.nxmINTR  = nxm_q;
  assign bus.nxdINTR  = nxd_q;
  assign bus.errADDR  = err_addr_q;
  assign bus.errCOUNT = err_cnt_q;

endmodule

// File: tb/tb_bus_tmo.sv
// Self-checking bench for bus_tmo: directed scenarios plus randomized transactions
// scored against a transaction-level model of the flags, counter and stall length.
module tb_bus_tmo;

  localparam int TMO     = 16;
  localparam int CNT_W   = 5;
  localparam int ADDR_W  = 36;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  localparam int K_ACK   = 0;
  localparam int K_ABORT = 1;
  localparam int K_TMO   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_tmo_if #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) bus ();

  bus_tmo #(
    .TMO_CYCLES(TMO),
    .CNT_W     (CNT_W),
    .ADDR_W    (ADDR_W),
    .ERR_W     (ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: what the sticky outputs should hold after each transaction.
  bit                exp_nxm;
  bit                exp_nxd;
  int                exp_cnt;
  logic [ADDR_W-1:0] exp_addr;

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_nxm = 1'b0;
    exp_nxd = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic model_txn(input bit io, input logic [ADDR_W-1:0] addr, input int kind,
                           input bit clr_fail);
    if (kind == K_TMO) begin
      if (clr_fail) model_clear();
      if (io) exp_nxd = 1'b1;
      else    exp_nxm = 1'b1;
      exp_addr = addr;
      exp_cnt  = (exp_cnt == ERR_MAX) ? ERR_MAX : exp_cnt + 1;
    end
  endtask

  // One complete bus cycle from IDLE back to IDLE. n is the WAIT-cycle index of the
  // acknowledge or the abort; drain is how many cycles busREQ stays high after completion.
  task automatic run_txn(input bit io, input logic [ADDR_W-1:0] addr, input int kind,
                         input int n, input bit clr_fail, input int drain, input string tag);
    int hi;
    int exp_hi;
    bit last;
    hi = 0;
    bus.busREQ  = 1'b1;
    bus.busIO   = io;
    bus.busADDR = addr;
    settle();
    hi += int'(bus.busWAIT);
    next();
    // Scramble the request lines so only the captured copies can be reported.
    bus.busIO   = !io;
    bus.busADDR = ~addr;
    for (int i = 0; i < TMO; i++) begin
      last = (kind != K_TMO) && (i == n);
      if (kind == K_ACK && i == n)                  bus.busACK = 1'b1;
      if (kind == K_ABORT && i == n)                bus.busREQ = 1'b0;
      if (kind == K_TMO && clr_fail && i == TMO-1)  bus.errCLR = 1'b1;
      settle();
      hi += int'(bus.busWAIT);
      next();
      bus.busACK = 1'b0;
      bus.errCLR = 1'b0;
      if (last) break;
    end
    if (kind != K_ABORT) begin
      if (kind == K_TMO) begin
        settle();
        hi += int'(bus.busWAIT);
        tests_run++;
        if (bus.ioBUSY !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s fail_busy: ioBUSY got %b want 1", tag, bus.ioBUSY);
        end
        next();
      end
      for (int d = 0; d < drain; d++) begin
        // Acknowledge outside WAIT must be ignored.
        bus.busACK = 1'($urandom_range(1, 0));
        settle();
        hi += int'(bus.busWAIT);
        tests_run++;
        if (bus.ioBUSY !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s drain_busy: ioBUSY got %b want 1", tag, bus.ioBUSY);
        end
        next();
        bus.busACK = 1'b0;
      end
      bus.busREQ = 1'b0;
      settle();
      hi += int'(bus.busWAIT);
      next();
    end
    settle();
    exp_hi = (kind == K_ACK) ? n + 1 : (kind == K_ABORT) ? n + 2 : TMO + 1;
    model_txn(io, addr, kind, clr_fail);
    tests_run++;
    if (hi !== exp_hi) begin
      tests_failed++;
      $display("FAIL %s wait_len: busWAIT cycles got %0d want %0d", tag, hi, exp_hi);
    end
    tests_run++;
    if (bus.ioBUSY !== 1'b0 || bus.busWAIT !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle: ioBUSY/busWAIT got %b/%b want 0/0", tag, bus.ioBUSY, bus.busWAIT);
    end
    tests_run++;
    if (bus.nxmINTR !== exp_nxm || bus.nxdINTR !== exp_nxd) begin
      tests_failed++;
      $display("FAIL %s flags: nxm/nxd got %b/%b want %b/%b", tag, bus.nxmINTR, bus.nxdINTR,
               exp_nxm, exp_nxd);
    end
    tests_run++;
    if (bus.errCOUNT !== ERR_W'(exp_cnt)) begin
      tests_failed++;
      $display("FAIL %s count: errCOUNT got %0d want %0d", tag, bus.errCOUNT, exp_cnt);
    end
    tests_run++;
    if (bus.errADDR !== exp_addr) begin
      tests_failed++;
      $display("FAIL %s addr: errADDR got %o want %o", tag, bus.errADDR, exp_addr);
    end
    next();
  endtask

  task automatic pulse_clr();
    bus.errCLR = 1'b1;
    bus.busACK = 1'($urandom_range(1, 0));
    settle();
    next();
    bus.errCLR = 1'b0;
    bus.busACK = 1'b0;
    model_clear();
    settle();
    tests_run++;
    if (bus.errCOUNT !== '0 || bus.nxmINTR !== 1'b0 || bus.nxdINTR !== 1'b0 ||
        bus.ioBUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr: cnt/nxm/nxd/busy got %0d/%b/%b/%b want 0/0/0/0", bus.errCOUNT,
               bus.nxmINTR, bus.nxdINTR, bus.ioBUSY);
    end
    next();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.busREQ  = 1'b1;
    bus.busIO   = 1'b0;
    bus.busADDR = '0;
    bus.busACK  = 1'b0;
    bus.errCLR  = 1'b0;
    repeat (3) next();
    settle();
    tests_run++;
    if (bus.busWAIT !== 1'b0 || bus.ioBUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busWAIT/ioBUSY got %b/%b want 0/0", bus.busWAIT, bus.ioBUSY);
    end
    tests_run++;
    if (bus.nxmINTR !== 1'b0 || bus.nxdINTR !== 1'b0 || bus.errCOUNT !== '0 ||
        bus.errADDR !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: nxm/nxd/cnt/addr got %b/%b/%0d/%o want 0/0/0/0",
               bus.nxmINTR, bus.nxdINTR, bus.errCOUNT, bus.errADDR);
    end
    next();
    rst        = 1'b0;
    bus.busREQ = 1'b0;
    model_clear();
    exp_addr = '0;
    next();
  endtask

  task automatic test_mem_ack();
    run_txn(1'b0, 36'o000000004321, K_ACK, 2, 1'b0, 1, "mem_ack3");
  endtask

  task automatic test_mem_timeout();
    run_txn(1'b0, 36'o000000001234, K_TMO, 0, 1'b0, 2, "mem_tmo");
    tests_run++;
    if (bus.errADDR !== 36'o000000001234 || bus.nxmINTR !== 1'b1 || bus.errCOUNT !== 8'd1) begin
      tests_failed++;
      $display("FAIL mem_tmo_abs: addr/nxm/cnt got %o/%b/%0d want 1234/1/1", bus.errADDR,
               bus.nxmINTR, bus.errCOUNT);
    end
  endtask

  task automatic test_io_timeout();
    pulse_clr();
    run_txn(1'b1, 36'o777700000001, K_TMO, 0, 1'b0, 1, "io_tmo");
  endtask

  task automatic test_ack_at_timeout();
    pulse_clr();
    run_txn(1'b0, 36'o123456701234, K_ACK, TMO - 1, 1'b0, 2, "ack_at_tmo");
  endtask

  task automatic test_abort();
    run_txn(1'b1, 36'o000011112222, K_ABORT, 4, 1'b0, 0, "abort");
  endtask

  task automatic test_clr_collision();
    pulse_clr();
    for (int k = 0; k < 5; k++) run_txn(1'($urandom_range(1, 0)), 36'(k + 1), K_TMO, 0,
                                        1'b0, 1, "pre_collision");
    run_txn(1'b0, 36'o000000000077, K_TMO, 0, 1'b1, 1, "clr_collision");
  endtask

  task automatic test_saturation();
    pulse_clr();
    for (int k = 0; k < 300; k++) run_txn(1'b0, 36'(k), K_TMO, 0, 1'b0, 1, "saturate");
    tests_run++;
    if (bus.errCOUNT !== 8'd255) begin
      tests_failed++;
      $display("FAIL saturate_final: errCOUNT got %0d want 255", bus.errCOUNT);
    end
  endtask

  task automatic test_reset_mid_wait();
    pulse_clr();
    bus.busREQ  = 1'b1;
    bus.busIO   = 1'b0;
    bus.busADDR = 36'o000000005555;
    next();
    for (int i = 0; i < 9; i++) next();
    rst = 1'b1;
    settle();
    tests_run++;
    if (bus.busWAIT !== 1'b0 || bus.ioBUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_during: busWAIT/ioBUSY got %b/%b want 0/0", bus.busWAIT, bus.ioBUSY);
    end
    next();
    rst        = 1'b0;
    bus.busREQ = 1'b0;
    model_clear();
    exp_addr = '0;
    settle();
    tests_run++;
    if (bus.busWAIT !== 1'b0 || bus.ioBUSY !== 1'b0 || bus.nxmINTR !== 1'b0 ||
        bus.nxdINTR !== 1'b0 || bus.errCOUNT !== '0) begin
      tests_failed++;
      $display("FAIL rst_wait_after: wait/busy/nxm/nxd/cnt got %b/%b/%b/%b/%0d want 0/0/0/0/0",
               bus.busWAIT, bus.ioBUSY, bus.nxmINTR, bus.nxdINTR, bus.errCOUNT);
    end
    next();
    // A full timeout after the reset must still be counted from zero.
    run_txn(1'b1, 36'o000000000042, K_TMO, 0, 1'b0, 1, "post_reset_tmo");
  endtask

  task automatic test_random();
    int                kind;
    int                n;
    bit                io;
    bit                clr_fail;
    logic [ADDR_W-1:0] addr;
    for (int t = 0; t < 60; t++) begin
      kind     = int'($urandom_range(2, 0));
      io       = 1'($urandom_range(1, 0));
      addr     = {4'($urandom), 32'($urandom)};
      clr_fail = (kind == K_TMO) && ($urandom_range(3, 0) == 0);
      n        = (kind == K_ACK)   ? int'($urandom_range(TMO - 1, 0)) :
                 (kind == K_ABORT) ? int'($urandom_range(TMO - 2, 0)) : 0;
      if ($urandom_range(7, 0) == 0) pulse_clr();
      run_txn(io, addr, kind, n, clr_fail, int'($urandom_range(3, 1)), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mem_ack();
    test_mem_timeout();
    test_io_timeout();
    test_ack_at_timeout();
    test_abort();
    test_clr_collision();
    test_random();
    test_saturation();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_tmo.md
BUS_TMO -- requirements
Module: bus_tmo

Interface
REQ-001 Parameter TMO_CYCLES, default 16: number of WAIT cycles without acknowledge before a request is declared failed; legal range 2..2**CNT_W.
REQ-002 Parameter CNT_W, default 5: width of the timeout counter.
REQ-003 Parameter ADDR_W, default 36: width of the captured bus address.
REQ-004 Parameter ERR_W, default 8: width of the saturating error counter.
REQ-005 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port busREQ, input, 1: CPU bus request, held high until the cycle completes.
REQ-008 Port busIO, input, 1: request type, 1 = IO device cycle, 0 = memory cycle; sampled with busREQ.
REQ-009 Port busADDR, input, [0:ADDR_W-1]: request address; sampled with busREQ.
REQ-010 Port busACK, input, 1: acknowledge from the addressed memory or device.
REQ-011 Port errCLR, input, 1: one-cycle pulse that clears the sticky flags and the error counter.
REQ-012 Port busWAIT, output, 1: stall to the CPU timing logic while a request is outstanding.
REQ-013 Port nxmINTR, output, [1]: sticky non-existent-memory flag.
REQ-014 Port nxdINTR, output, [1]: sticky non-existent-device flag.
REQ-015 Port ioBUSY, output, 1: high whenever state is not IDLE.
REQ-016 Port errADDR, output, [0:ADDR_W-1]: address of the most recent failed request.
REQ-017 Port errCOUNT, output, [ERR_W]: number of failed requests, saturating.

Function
REQ-018 The FSM SHALL have four states: IDLE, WAIT, FAIL and DRAIN.
REQ-019 In IDLE with busREQ=1, the block SHALL go to WAIT, capture busIO and busADDR into holding registers and clear the counter to 0.
REQ-020 In WAIT with busACK=1, the block SHALL go to DRAIN; the counter is not compared in that cycle.
REQ-021 In WAIT with busACK=0, the counter SHALL increment. When the counter equals TMO_CYCLES-1, the block SHALL go to FAIL instead.
REQ-022 busACK and timeout in the same cycle: acknowledge wins, the request is not failed.
REQ-023 In WAIT, busREQ dropping before acknowledge SHALL abort the cycle and send the block to IDLE; no flag is set.
REQ-024 FAIL SHALL last exactly one cycle and then go to DRAIN. On entry to FAIL:
 - set nxdINTR if the held busIO=1, else set nxmINTR;
 - load errADDR from the held address;
 - increment errCOUNT unless it is all ones.
REQ-025 DRAIN SHALL hold until busREQ=0, then go to IDLE. A new request is accepted no earlier than the cycle after IDLE is re-entered.
REQ-026 busWAIT SHALL be combinational and equal (IDLE and busREQ) or (WAIT and not busACK). It SHALL be low in FAIL and DRAIN, so a failed cycle releases the CPU.
REQ-027 busACK outside WAIT SHALL be ignored.
REQ-028 errCLR SHALL zero nxmINTR, nxdINTR and errCOUNT. errADDR is not cleared.
REQ-029 errCLR in the same cycle as a FAIL-entry update: the set and increment win; errCOUNT becomes 1 when it was cleared concurrently.
REQ-030 errCOUNT SHALL saturate at 2**ERR_W-1 and never wrap.
REQ-031 The block SHALL NOT contain latches or multicycle paths.

Reset
REQ-032 Reset SHALL force state IDLE, counter 0, holding registers 0, nxmINTR=0, nxdINTR=0, errADDR=0 and errCOUNT=0.
REQ-033 Reset in any state, including mid-WAIT and FAIL, SHALL abandon the cycle with no flag or count update.
REQ-034 While rst=1, busWAIT SHALL be driven 0 and ioBUSY SHALL be 0.

Verification
REQ-035 Memory request acked after 3 cycles:
 - busWAIT is high for 3 cycles and drops in the acknowledge cycle;
 - no flags are set; errCOUNT=0.
REQ-036 Memory request at address 0o000000001234, never acked, default parameters:
 - busWAIT is high for 16 WAIT cycles plus the request cycle;
 - then nxmINTR=1, errADDR=0o1234, errCOUNT=1;
 - the block returns to IDLE after busREQ drops.
REQ-037 IO request, never acked: nxdINTR=1 and nxmINTR stays 0.
REQ-038 busACK arriving exactly in the timeout cycle: no flag is set and the block enters DRAIN.
REQ-039 errCLR coincident with a FAIL entry while errCOUNT=5: errCOUNT=1 and the flag is set. Separately, 300 timeouts with ERR_W=8: errCOUNT=255.
REQ-040 Reset asserted in the 10th WAIT cycle: the next cycle is IDLE with busWAIT=0, flags 0 and errCOUNT unchanged at 0.
